credit_fifo_tx: RTL and testbench

Credit-based transmitter that drives the write side of a downstream FIFO. The FIFO write side has valid/data only and no ready, so this block must never overrun it.
- Tracks free downstream slots with a credit counter.
- Accepts words from an upstream valid/ready source and emits them as single-cycle registered write pulses.
- Each pop from the downstream FIFO is returned as a credit pulse.
- Includes a drain FSM so software or a controller can quiesce the link before reset or reconfiguration.

---
 rtl/credit_fifo_tx.sv | 93 +++++++++
 tb/tb_credit_fifo_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/credit_fifo_tx.sv
// Credit-based transmitter for a downstream FIFO write port that has no ready.
// Optional stall statistic counter enabled by defining CREDIT_FIFO_TX_STATS_EN.
module credit_fifo_tx #(
   parameter int WIDTH   = 32,
   parameter int CREDITS = 128,
   localparam int CW     = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] IN_data,
   input  logic             IN_valid,
   output logic             OUT_ready,
   output logic [WIDTH-1:0] OUT_data,
   output logic             OUT_valid,
   input  logic             IN_creditRet,
   input  logic             IN_drain,
   output logic             OUT_drained,
   output logic [CW-1:0]    OUT_credits,
   output logic             OUT_err,
   output logic [31:0]      OUT_stallCycles
);

   // HOLD is the quiet tail of DONE: drained, but no longer pulsing OUT_drained
   typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

   state_t        state, state_next;
   logic [CW-1:0] credits;
   logic [CW:0]   credit_sum;
   logic          accept;
   logic          overflow;

   assign OUT_ready   = (state == RUN) && (credits != '0);
   assign accept      = IN_valid && OUT_ready;
   assign OUT_credits = credits;

   // The sum can only exceed CREDITS on a return with the counter already full
   assign credit_sum = {1'b0, credits} - {{CW{1'b0}}, accept} + {{CW{1'b0}}, IN_creditRet};
   assign overflow   = credit_sum > (CW + 1)'(CREDITS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits   <= CW'(CREDITS);
         OUT_err   <= 1'b0;
         OUT_valid <= 1'b0;
         OUT_data  <= '0;
         state     <= RUN;
      end else begin
         if (!overflow)
            credits <= credit_sum[CW-1:0];
         OUT_err   <= OUT_err | overflow;
         OUT_valid <= accept;
         if (accept)
            OUT_data <= IN_data;
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      OUT_drained = 1'b0;
      unique case (state)
         RUN:   if (IN_drain) state_next = DRAIN;
         DRAIN: begin
            if (!IN_drain)
               state_next = RUN;
            else if (credits == CW'(CREDITS) && !OUT_valid)
               state_next = DONE;
         end
         DONE: begin
            OUT_drained = 1'b1;
            state_next  = IN_drain ? HOLD : RUN;
         end
         HOLD:  if (!IN_drain) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

`ifdef CREDIT_FIFO_TX_STATS_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (IN_valid && !OUT_ready && state == RUN && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign OUT_stallCycles = stall_cnt;
`else
   assign OUT_stallCycles = '0;
`endif

endmodule

// File: tb/tb_credit_fifo_tx.sv
// Scoreboard bench for credit_fifo_tx with CREDITS=4, WIDTH=8: stimulus queues
// expected writes with their due cycle, a negedge monitor checks them.
module tb_credit_fifo_tx;

   localparam int WIDTH   = 8;
   localparam int CREDITS = 4;
   localparam int CW      = $clog2(CREDITS + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] IN_data;
   logic             IN_valid;
   logic             OUT_ready;
   logic [WIDTH-1:0] OUT_data;
   logic             OUT_valid;
   logic             IN_creditRet;
   logic             IN_drain;
   logic             OUT_drained;
   logic [CW-1:0]    OUT_credits;
   logic             OUT_err;
   logic [31:0]      OUT_stallCycles;

   credit_fifo_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
      .clk(clk), .rst(rst),
      .IN_data(IN_data), .IN_valid(IN_valid), .OUT_ready(OUT_ready),
      .OUT_data(OUT_data), .OUT_valid(OUT_valid),
      .IN_creditRet(IN_creditRet), .IN_drain(IN_drain),
      .OUT_drained(OUT_drained), .OUT_credits(OUT_credits),
      .OUT_err(OUT_err), .OUT_stallCycles(OUT_stallCycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   drained_pulses = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued word and its due cycle
   always @(negedge clk) begin
      if (!rst && OUT_drained) drained_pulses++;
      if (!rst && OUT_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got data %0h at cycle %0d, expected no write", OUT_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (OUT_data !== e.data || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL write: got data %0h at cycle %0d, expected data %0h at cycle %0d",
                        OUT_data, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Accept happens at the next edge; the write is visible in the cycle that edge starts
   task automatic expect_write(input logic [WIDTH-1:0] d);
      exp_t e;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; IN_data = '0; IN_valid = 1'b0; IN_creditRet = 1'b0; IN_drain = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("reset_credits", 32'(OUT_credits), 32'd4);
      chk("reset_ready", 32'(OUT_ready), 32'd1);
      chk("reset_valid_data", {23'd0, OUT_valid, OUT_data}, 32'd0);
      chk("reset_err_drained", {30'd0, OUT_err, OUT_drained}, 32'd0);
      chk("reset_stall", OUT_stallCycles, 32'd0);

      // Words 1..4 consume all credits; word 5 stays held upstream
      IN_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         IN_data = WIDTH'(i);
         expect_write(WIDTH'(i));
         step(1);
      end
      IN_data = 8'd5;
      chk("empty_credits", 32'(OUT_credits), 32'd0);
      chk("empty_ready", 32'(OUT_ready), 32'd0);
      step(10);
      chk("held_credits", 32'(OUT_credits), 32'd0);
`ifdef CREDIT_FIFO_TX_STATS_EN
      chk("stall_count", OUT_stallCycles, 32'd10);
`else
      chk("stall_count", OUT_stallCycles, 32'd0);
`endif

      // One returned credit releases word 5
      IN_creditRet = 1'b1;
      step(1);
      IN_creditRet = 1'b0;
      chk("one_credit", 32'(OUT_credits), 32'd1);
      chk("one_credit_ready", 32'(OUT_ready), 32'd1);
      expect_write(8'd5);
      step(1);
      IN_valid = 1'b0;
      chk("last_credit_used", 32'(OUT_credits), 32'd0);
      chk("last_credit_ready", 32'(OUT_ready), 32'd0);

      // Build up to 2 credits, then accept and return in the same cycle
      IN_creditRet = 1'b1;
      step(2);
      chk("two_credits", 32'(OUT_credits), 32'd2);
      IN_valid = 1'b1; IN_data = 8'hA5;
      expect_write(8'hA5);
      step(1);
      IN_valid = 1'b0; IN_creditRet = 1'b0;
      chk("simul_accept_ret", 32'(OUT_credits), 32'd2);
      step(1);

      // Drain with two words outstanding
      IN_drain = 1'b1;
      step(1);
      chk("drain_ready", 32'(OUT_ready), 32'd0);
      IN_creditRet = 1'b1;
      step(1);
      chk("drain_ret_counted", 32'(OUT_credits), 32'd3);
      step(1);
      IN_creditRet = 1'b0;
      chk("drain_full", {31'd0, OUT_drained}, 32'd0);
      chk("drain_full_credits", 32'(OUT_credits), 32'd4);
      step(1);
      chk("drained_pulse", {31'd0, OUT_drained}, 32'd1);
      step(1);
      chk("drained_hold", {30'd0, OUT_drained, OUT_ready}, 32'd0);
      step(2);
      IN_drain = 1'b0;
      step(1);
      chk("undrain_ready", 32'(OUT_ready), 32'd1);

      // Word accepted as drain rises is still written; lowering drain aborts without a pulse
      IN_valid = 1'b1; IN_drain = 1'b1; IN_data = 8'h3C;
      expect_write(8'h3C);
      step(1);
      IN_valid = 1'b0;
      step(3);
      chk("drain_wait_credits", 32'(OUT_credits), 32'd3);
      IN_drain = 1'b0;
      step(1);
      chk("abort_ready", 32'(OUT_ready), 32'd1);
      IN_creditRet = 1'b1;
      step(1);
      IN_creditRet = 1'b0;
      chk("restored_credits", 32'(OUT_credits), 32'd4);
      chk("drained_count", 32'(drained_pulses), 32'd1);

      // Return while full is an overflow: ignored, sticky error until reset
      IN_creditRet = 1'b1;
      step(1);
      IN_creditRet = 1'b0;
      chk("overflow_err", 32'(OUT_err), 32'd1);
      chk("overflow_credits", 32'(OUT_credits), 32'd4);
      step(3);
      chk("err_sticky", 32'(OUT_err), 32'd1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      chk("err_cleared", 32'(OUT_err), 32'd0);
      chk("post_rst_credits", 32'(OUT_credits), 32'd4);
      chk("post_rst_stall", OUT_stallCycles, 32'd0);

      step(2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
